pll_phase_ctrl: RTL

Runtime dynamic phase-shift controller for the Gowin GW5A PLL. It replaces compile-time CLKOUTn_PE_COARSE/FINE tuning with per-channel tracked phase. It accepts absolute phase targets over a valid/ready handshake and drives the PLL PSSEL/PSDIR/PSPULSE pins with the shortest-path sequence of fine steps. It sits beside the PLL wrapper in the board top and is used for SDRAM clock-phase tuning.

---
 rtl/pll_phase_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/pll_phase_ctrl.sv
// pll_phase_ctrl: runtime shortest-path phase stepper for GW5A PLL outputs (PSSEL/PSDIR/PSPULSE).
// Define PLL_PS_SWEEP_EN to add the per-channel calibration sweep.
module pll_phase_ctrl #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned STEPS      = 80,
  parameter int unsigned PW         = 7,
  parameter int unsigned INIT_PHASE = 54,
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned PULSE_W    = 4,
  parameter int unsigned GAP_W      = 8
`ifdef PLL_PS_SWEEP_EN
  ,
  parameter int unsigned SETTLE     = 64
`endif
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 lock,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [2:0]           req_ch,
  input  logic [PW-1:0]        req_target,
  output logic [2:0]           pssel,
  output logic                 psdir,
  output logic                 pspulse,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [NUM_CH*PW-1:0] phase_out
`ifdef PLL_PS_SWEEP_EN
  ,
  input  logic                 sweep_start,
  input  logic [2:0]           sweep_ch,
  input  logic                 test_pass,
  output logic                 sweep_done,
  output logic                 sweep_fail
`endif
);

  localparam int unsigned DW    = PW + 1;
  localparam int unsigned CMAX0 = (SETUP_CYC > PULSE_W) ? SETUP_CYC : PULSE_W;
  localparam int unsigned CMAX1 = (CMAX0 > GAP_W) ? CMAX0 : GAP_W;
`ifdef PLL_PS_SWEEP_EN
  localparam int unsigned CMAX  = (CMAX1 > SETTLE) ? CMAX1 : SETTLE;
`else
  localparam int unsigned CMAX  = CMAX1;
`endif
  localparam int unsigned CW    = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_PULSE, S_GAP, S_DONE
`ifdef PLL_PS_SWEEP_EN
    , S_SW_MOVE, S_SW_SETTLE, S_SW_NEXT
`endif
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [PW-1:0] nstep, nstep_n;
  logic [2:0]    ch_n;
  logic          dir_n, err_n, lost, lost_n, step_c;
  logic          ch_ok, tgt_ok;

  // Shortest-path move calculation against the tracked phase of mv_ch
  logic [2:0]    mv_ch;
  logic [PW-1:0] mv_tgt, mv_cur, act_cur, step_val, mv_n;
  logic [DW-1:0] mv_sum, mv_d;
  logic          mv_up;

`ifdef PLL_PS_SWEEP_EN
  typedef enum logic [1:0] {ST_TO0, ST_SCAN, ST_CENTER, ST_RESTORE} stage_t;
  stage_t        sw_stage, sw_stage_n;
  logic          sw_act, sw_act_n, sw_bad_c, sw_end_c;
  logic [PW-1:0] sw_tgt, sw_tgt_n, sw_save, sw_save_n, sw_p, sw_p_n;
  logic [PW-1:0] cur_start, cur_start_n, best_start, best_start_n, centre;
  logic [DW-1:0] cur_len, cur_len_n, best_len, best_len_n;
  logic [DW:0]   ctr_sum;
`endif

  assign req_ready = (state == S_IDLE) && lock;
  assign ch_ok     = req_ch < 3'(NUM_CH);
  assign tgt_ok    = DW'(req_target) < DW'(STEPS);

  always_comb begin
    mv_ch  = req_ch;
    mv_tgt = req_target;
`ifdef PLL_PS_SWEEP_EN
    if (state == S_SW_MOVE) begin
      mv_ch  = pssel;
      mv_tgt = sw_tgt;
    end
`endif
    mv_cur  = '0;
    act_cur = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (3'(i) == mv_ch) mv_cur  = phase_out[i*PW +: PW];
      if (3'(i) == pssel) act_cur = phase_out[i*PW +: PW];
    end
    mv_sum = DW'(mv_tgt) + DW'(STEPS) - DW'(mv_cur);
    mv_d   = (mv_sum >= DW'(STEPS)) ? mv_sum - DW'(STEPS) : mv_sum;
    mv_up  = mv_d <= DW'(STEPS / 2);
    mv_n   = mv_up ? PW'(mv_d) : PW'(DW'(STEPS) - mv_d);
    if (psdir) step_val = (act_cur == PW'(STEPS - 1)) ? '0 : act_cur + PW'(1);
    else       step_val = (act_cur == '0) ? PW'(STEPS - 1) : act_cur - PW'(1);
  end

`ifdef PLL_PS_SWEEP_EN
  assign ctr_sum = (DW+1)'(best_start) + (DW+1)'(best_start) + (DW+1)'(best_len) - (DW+1)'(1);
  assign centre  = PW'(ctr_sum >> 1);
`endif

  // Next-state and datapath updates
  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    nstep_n = nstep;
    ch_n    = pssel;
    dir_n   = psdir;
    err_n   = err;
    lost_n  = lost;
    step_c  = 1'b0;
`ifdef PLL_PS_SWEEP_EN
    sw_stage_n   = sw_stage;
    sw_act_n     = sw_act;
    sw_bad_c     = 1'b0;
    sw_tgt_n     = sw_tgt;
    sw_save_n    = sw_save;
    sw_p_n       = sw_p;
    cur_start_n  = cur_start;
    cur_len_n    = cur_len;
    best_start_n = best_start;
    best_len_n   = best_len;
`endif
    unique case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (req_valid && req_ready) begin
          lost_n = 1'b0;
          if (!ch_ok || !tgt_ok) begin
            state_n = S_DONE;
            err_n   = 1'b1;
          end else if (mv_d == '0) begin
            state_n = S_DONE;
            err_n   = 1'b0;
          end else begin
            state_n = S_SETUP;
            ch_n    = req_ch;
            dir_n   = mv_up;
            nstep_n = mv_n;
          end
        end
`ifdef PLL_PS_SWEEP_EN
        else if (sweep_start && lock) begin
          lost_n = 1'b0;
          if (sweep_ch >= 3'(NUM_CH)) begin
            state_n  = S_DONE;
            err_n    = 1'b1;
            sw_bad_c = 1'b1;
          end else begin
            state_n    = S_SW_MOVE;
            ch_n       = sweep_ch;
            sw_act_n   = 1'b1;
            sw_stage_n = ST_TO0;
            sw_tgt_n   = '0;
            cur_len_n  = '0;
            best_len_n = '0;
          end
        end
`endif
      end
      S_SETUP: begin
        lost_n = lost | ~lock;
        if (cnt == CW'(SETUP_CYC - 1)) begin
          cnt_n = '0;
          if (lost_n) begin
            state_n = S_DONE;
            err_n   = 1'b1;
          end else begin
            state_n = S_PULSE;
          end
        end
      end
      S_PULSE: begin
        lost_n = lost | ~lock;
        if (cnt == CW'(PULSE_W - 1)) begin
          cnt_n   = '0;
          step_c  = 1'b1;
          nstep_n = nstep - PW'(1);
          state_n = S_GAP;
        end
      end
      S_GAP: begin
        lost_n = lost | ~lock;
        if (cnt == CW'(GAP_W - 1)) begin
          cnt_n = '0;
          if (lost_n) begin
            state_n = S_DONE;
            err_n   = 1'b1;
          end else if (nstep == '0) begin
            state_n = S_DONE;
            err_n   = 1'b0;
`ifdef PLL_PS_SWEEP_EN
            if (sw_act) state_n = S_SW_NEXT;
`endif
          end else begin
            state_n = S_PULSE;
          end
        end
      end
      S_DONE: begin
        cnt_n   = '0;
        state_n = S_IDLE;
`ifdef PLL_PS_SWEEP_EN
        sw_act_n = 1'b0;
`endif
      end
`ifdef PLL_PS_SWEEP_EN
      S_SW_MOVE: begin
        cnt_n = '0;
        if (sw_stage == ST_TO0) sw_save_n = mv_cur;
        if (mv_d == '0) begin
          state_n = S_SW_NEXT;
        end else begin
          state_n = S_SETUP;
          dir_n   = mv_up;
          nstep_n = mv_n;
        end
      end
      S_SW_SETTLE: begin
        if (cnt == CW'(SETTLE - 1)) begin
          cnt_n = '0;
          // Longest linear passing run; strict compare keeps the earliest on ties
          if (test_pass) begin
            cur_len_n   = cur_len + DW'(1);
            cur_start_n = (cur_len == '0) ? sw_p : cur_start;
            if (cur_len_n > best_len) begin
              best_len_n   = cur_len_n;
              best_start_n = cur_start_n;
            end
          end else begin
            cur_len_n = '0;
          end
          dir_n   = 1'b1;
          nstep_n = PW'(1);
          state_n = S_SETUP;
        end
      end
      S_SW_NEXT: begin
        cnt_n = '0;
        unique case (sw_stage)
          ST_TO0: begin
            sw_stage_n = ST_SCAN;
            sw_p_n     = '0;
            state_n    = S_SW_SETTLE;
          end
          ST_SCAN: begin
            if (sw_p == PW'(STEPS - 1)) begin
              state_n = S_SW_MOVE;
              if (best_len == '0) begin
                sw_stage_n = ST_RESTORE;
                sw_tgt_n   = sw_save;
              end else begin
                sw_stage_n = ST_CENTER;
                sw_tgt_n   = centre;
              end
            end else begin
              sw_p_n  = sw_p + PW'(1);
              state_n = S_SW_SETTLE;
            end
          end
          ST_CENTER: begin
            state_n = S_DONE;
            err_n   = 1'b0;
          end
          default: begin
            state_n = S_DONE;
            err_n   = 1'b1;
          end
        endcase
      end
`endif
      default: state_n = S_IDLE;
    endcase
`ifdef PLL_PS_SWEEP_EN
    sw_end_c = (state_n == S_DONE) && (state != S_DONE) && (sw_act || sw_bad_c);
`endif
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= S_IDLE;
      cnt     <= '0;
      nstep   <= '0;
      pssel   <= '0;
      psdir   <= 1'b0;
      pspulse <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      lost    <= 1'b0;
      for (int i = 0; i < int'(NUM_CH); i++) phase_out[i*PW +: PW] <= PW'(INIT_PHASE);
`ifdef PLL_PS_SWEEP_EN
      sw_stage   <= ST_TO0;
      sw_act     <= 1'b0;
      sw_tgt     <= '0;
      sw_save    <= '0;
      sw_p       <= '0;
      cur_start  <= '0;
      cur_len    <= '0;
      best_start <= '0;
      best_len   <= '0;
      sweep_done <= 1'b0;
      sweep_fail <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      nstep   <= nstep_n;
      pssel   <= ch_n;
      psdir   <= dir_n;
      pspulse <= (state_n == S_PULSE);
      busy    <= (state_n != S_IDLE);
      done    <= (state_n == S_DONE);
      err     <= err_n;
      lost    <= lost_n;
      if (step_c) begin
        for (int i = 0; i < int'(NUM_CH); i++)
          if (3'(i) == pssel) phase_out[i*PW +: PW] <= step_val;
      end
`ifdef PLL_PS_SWEEP_EN
      sw_stage   <= sw_stage_n;
      sw_act     <= sw_act_n;
      sw_tgt     <= sw_tgt_n;
      sw_save    <= sw_save_n;
      sw_p       <= sw_p_n;
      cur_start  <= cur_start_n;
      cur_len    <= cur_len_n;
      best_start <= best_start_n;
      best_len   <= best_len_n;
      sweep_done <= sw_end_c;
      if (sw_end_c) sweep_fail <= err_n;
`endif
    end
  end

endmodule
